rom_port_arbiter: RTL and testbench
===================================

Name: rom_port_arbiter

Overview:
- Shares the single-port synchronous instruction ROM between two requesters: the instruction-fetch stage (IF) and the data-memory stage (DM), which issues constant/table loads that hit the ROM address window.
- Performs grant arbitration, ROM address generation and response steering.
- Bounds IF starvation and supports squashing an in-flight fetch on a pipeline flush.
- Sits between the IF/MEM stages and the ROM.

Parameters:
- ROM_AW, 8, ROM word-address width; ROM word address = byte_addr[ROM_AW+1:2].
- ROM_DEPTH, 203, number of populated ROM words; word addresses >= ROM_DEPTH are out of range.
- MAX_WAIT, 4, consecutive cycles IF may be denied before it is force-granted.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  IF read request; level, held until granted.
- if_addr  in  32  IF byte address.
- if_flush  in  1  squash IF response due next cycle.
- if_gnt  out  1  IF request accepted this cycle (combinational).
- if_rvalid  out  1  IF read data valid.
- if_rdata  out  32  IF read data.
- dm_req  in  1  DM read request; level, held until granted.
- dm_addr  in  32  DM byte address.
- dm_gnt  out  1  DM request accepted this cycle (combinational).
- dm_rvalid  out  1  DM read data valid.
- dm_rdata  out  32  DM read data.
- dm_err  out  1  DM response out of range; qualifies dm_rvalid.
- rom_addr  out  ROM_AW  word address to ROM.
- rom_data  in  32  ROM read data; valid one cycle after rom_addr.

Behaviour:
- Reset: if_gnt=0, dm_gnt=0, if_rvalid=0, dm_rvalid=0, dm_err=0, if_rdata=0, dm_rdata=0, rom_addr=0, wait counter=0, owner register=NONE.
- Arbitration: at most one grant per cycle.
  - Default fixed priority: DM over IF.
  - If the wait counter == MAX_WAIT and if_req=1, IF wins regardless of dm_req.
- Wait counter:
  - Increments (saturating at MAX_WAIT) each cycle if_req=1 and if_gnt=0.
  - Clears on if_gnt or when if_req=0.
- rom_addr: driven combinationally from the granted requester's address[ROM_AW+1:2]; holds its last value when there is no grant. Address bits [1:0] are ignored.
- Owner register: records the grant (IF, DM, NONE) at posedge. Latency is exactly 1 cycle, grant to rvalid, fully pipelined; back-to-back grants are allowed every cycle.
- Response steering:
  - Owner=IF: if_rvalid=1, if_rdata=rom_data.
  - Owner=DM: dm_rvalid=1, dm_rdata=rom_data.
  - Non-owner rvalid=0; its rdata holds its previous value.
- Out of range: a DM word address >= ROM_DEPTH or upper bits [31:ROM_AW+2] != 0 is still granted. The response carries dm_rdata=0 and dm_err=1. IF out-of-range returns rom_data unmodified.
- Flush: if_flush=1 in the cycle an IF response is due suppresses if_rvalid; if_rdata is not updated. if_flush in the grant cycle does not block the grant.
- Simultaneous flush and new IF grant in the same cycle: the new grant's response is not affected by this flush.
- Reset mid-operation: an in-flight response is dropped and no rvalid is emitted in the cycle after rst.

Optional Feature:
- ROM_ARB_RR_EN defined: the priority rule becomes round-robin. The last-granted requester gets lowest priority next cycle. The MAX_WAIT override remains active but is never reached with two requesters.
- ROM_ARB_RR_EN undefined: fixed DM>IF priority with the starvation override as above.

Decomposition:
- Shared package holds:
  - typedef owner_e {OWN_NONE, OWN_IF, OWN_DM};
  - ROM_AW and ROM_DEPTH defaults, shared with the ROM instance;
  - the word-index extraction helper function.
- Natural sub-module: rom_arb_prio, the 2-way arbiter holding the wait counter and the round-robin pointer.
- Steering and range check stay in the top module.

Test Plan:
- Reset then IF-only, if_addr=0x0,0x4,0x8 on consecutive cycles -> if_gnt every cycle; if_rvalid cycles 2-4 with data 0x00608640, 0x00688040, 0x00010134.
- Both request continuously, dm_addr=0x100, if_addr=0x104, fixed priority, MAX_WAIT=4 -> dm_gnt 4 cycles, then if_gnt 1 cycle; IF receives mem[65]=0x20000634.
- DM read dm_addr=0x400 (word 256 >= 203) -> dm_rvalid=1, dm_err=1, dm_rdata=0; next in-range read clears dm_err.
- IF granted at cycle N, if_flush=1 at N+1 -> if_rvalid=0 at N+1; IF granted at N+1 returns normally at N+2.
- rst asserted the cycle after a DM grant -> dm_rvalid=0 and all outputs at reset values the next cycle.
- With ROM_ARB_RR_EN, both requesting continuously -> grants alternate IF/DM every cycle, each rvalid one cycle later with the correct word.

Source files
------------

// File: rtl/rom_port_arbiter_pkg.sv
// rtl/rom_port_arbiter_pkg.sv - shared ROM geometry, owner type and address helper
package rom_port_arbiter_pkg;

   // ROM geometry, shared with the ROM instance so both sides agree
   localparam int ROM_AW_DEFAULT    = 8;
   localparam int ROM_DEPTH_DEFAULT = 203;
   localparam int MAX_WAIT_DEFAULT  = 4;

   // Which requester the ROM word arriving next cycle belongs to
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } owner_e;

   // Full word index of a byte address; callers slice the ROM bits and
   // use the whole value for range checking
   function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
      return byte_addr >> 2;
   endfunction

endpackage

// File: rtl/rom_arb_prio.sv
// rtl/rom_arb_prio.sv - 2-way IF/DM arbiter with starvation counter; ROM_ARB_RR_EN selects round-robin
module rom_arb_prio
   import rom_port_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEFAULT
)
(
   input  logic clk,
   input  logic rst,
   input  logic i_if_req,
   input  logic i_dm_req,
   output logic o_if_gnt,
   output logic o_dm_gnt
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   logic [CW-1:0] r_wait_cnt;
   logic          w_force_if;
   logic          w_if_pref;

   // IF has been denied long enough that it must win this cycle
   assign w_force_if = (r_wait_cnt == CW'(MAX_WAIT));

`ifdef ROM_ARB_RR_EN
   logic r_last_dm;

   // Remember who was served last so the other side is preferred next
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_dm <= 1'b0;
      end else if (o_dm_gnt) begin
         r_last_dm <= 1'b1;
      end else if (o_if_gnt) begin
         r_last_dm <= 1'b0;
      end
   end

   assign w_if_pref = r_last_dm;
`else
   assign w_if_pref = 1'b0;
`endif

   // Grant decision: DM by default, IF when preferred, alone, or starved
   always_comb begin
      o_if_gnt = 1'b0;
      o_dm_gnt = 1'b0;
      if (!rst) begin
         if (i_if_req && (w_force_if || !i_dm_req || w_if_pref)) begin
            o_if_gnt = 1'b1;
         end else if (i_dm_req) begin
            o_dm_gnt = 1'b1;
         end
      end
   end

   // Count consecutive denied IF cycles, saturating at MAX_WAIT
   always_ff @(posedge clk) begin
      if (rst || !i_if_req || o_if_gnt) begin
         r_wait_cnt <= '0;
      end else if (r_wait_cnt != CW'(MAX_WAIT)) begin
         r_wait_cnt <= r_wait_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - shares the instruction ROM between IF and DM; ROM_ARB_RR_EN enables round-robin
module rom_port_arbiter
   import rom_port_arbiter_pkg::*;
#(
   parameter int ROM_AW    = ROM_AW_DEFAULT,
   parameter int ROM_DEPTH = ROM_DEPTH_DEFAULT,
   parameter int MAX_WAIT  = MAX_WAIT_DEFAULT
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   input  logic              if_flush,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              dm_req,
   input  logic [31:0]       dm_addr,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [31:0]       dm_rdata,
   output logic              dm_err,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [31:0]       rom_data
);

   logic [31:0]       w_if_word;
   logic [31:0]       w_dm_word;
   logic              w_dm_oor;
   logic              w_if_gnt;
   logic              w_dm_gnt;
   logic              w_if_valid;
   logic              w_dm_valid;
   logic [31:0]       w_dm_resp_data;
   logic              w_unused_if_bits;
   owner_e            w_owner_nxt;

   owner_e            r_owner;
   logic              r_dm_oor;
   logic [ROM_AW-1:0] r_rom_addr;
   logic [31:0]       r_if_rdata;
   logic [31:0]       r_dm_rdata;

   assign w_if_word = word_index(if_addr);
   assign w_dm_word = word_index(dm_addr);

   // IF out-of-range reads simply return whatever the ROM produces
   assign w_unused_if_bits = ^w_if_word[31:ROM_AW];

   // Any word beyond the populated depth (including nonzero upper bits)
   assign w_dm_oor = (w_dm_word >= 32'(ROM_DEPTH));

   rom_arb_prio #(
      .MAX_WAIT (MAX_WAIT)
   ) u_prio (
      .clk      (clk),
      .rst      (rst),
      .i_if_req (if_req),
      .i_dm_req (dm_req),
      .o_if_gnt (w_if_gnt),
      .o_dm_gnt (w_dm_gnt)
   );

   assign if_gnt = w_if_gnt;
   assign dm_gnt = w_dm_gnt;

   // ROM address follows the winner, otherwise holds the last address issued
   assign rom_addr = rst      ? '0 :
                     w_if_gnt ? w_if_word[ROM_AW-1:0] :
                     w_dm_gnt ? w_dm_word[ROM_AW-1:0] :
                                r_rom_addr;

   // Owner of the response due next cycle
   always_comb begin
      w_owner_nxt = OWN_NONE;
      if (w_if_gnt) begin
         w_owner_nxt = OWN_IF;
      end else if (w_dm_gnt) begin
         w_owner_nxt = OWN_DM;
      end
   end

   // A flush only cancels the response arriving now; a grant in the same
   // cycle is recorded normally and answered next cycle
   assign w_if_valid     = !rst && (r_owner == OWN_IF) && !if_flush;
   assign w_dm_valid     = !rst && (r_owner == OWN_DM);
   assign w_dm_resp_data = r_dm_oor ? 32'h0 : rom_data;

   assign if_rvalid = w_if_valid;
   assign if_rdata  = w_if_valid ? rom_data : r_if_rdata;
   assign dm_rvalid = w_dm_valid;
   assign dm_rdata  = w_dm_valid ? w_dm_resp_data : r_dm_rdata;
   assign dm_err    = w_dm_valid && r_dm_oor;

   // Pipeline the owner and range flag, and keep the last delivered data
   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner    <= OWN_NONE;
         r_dm_oor   <= 1'b0;
         r_rom_addr <= '0;
         r_if_rdata <= 32'h0;
         r_dm_rdata <= 32'h0;
      end else begin
         r_owner    <= w_owner_nxt;
         r_dm_oor   <= w_dm_gnt && w_dm_oor;
         r_rom_addr <= rom_addr;
         if (w_if_valid) begin
            r_if_rdata <= rom_data;
         end
         if (w_dm_valid) begin
            r_dm_rdata <= w_dm_resp_data;
         end
      end
   end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - directed-vector bench for rom_port_arbiter with a synchronous ROM model
module tb_rom_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_flush;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        dm_req;
   logic [31:0] dm_addr;
   logic        dm_gnt;
   logic        dm_rvalid;
   logic [31:0] dm_rdata;
   logic        dm_err;
   logic [7:0]  rom_addr;
   logic [31:0] rom_data;

   logic [31:0] mem [256];
   int          vec_cnt = 0;
   int          err_cnt = 0;
   logic [31:0] exp_if_hold;

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= mem[rom_addr];

   rom_port_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_flush  (if_flush),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .dm_req    (dm_req),
      .dm_addr   (dm_addr),
      .dm_gnt    (dm_gnt),
      .dm_rvalid (dm_rvalid),
      .dm_rdata  (dm_rdata),
      .dm_err    (dm_err),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                        input logic fl, input logic dr, input logic [31:0] da);
      @(negedge clk);
      rst      = r;
      if_req   = ir;
      if_addr  = ia;
      if_flush = fl;
      dm_req   = dr;
      dm_addr  = da;
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i * 32'h0001_0003;
      mem[0]  = 32'h0060_8640;
      mem[1]  = 32'h0068_8040;
      mem[2]  = 32'h0001_0134;
      mem[65] = 32'h2000_0634;
      rom_data = 32'h0;
      rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
      dm_req = 1'b0; dm_addr = 32'h0;

      // reset state
      drive(1, 0, 32'h0, 0, 0, 32'h0);
      drive(1, 1, 32'h4, 0, 1, 32'h8);
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_dm_gnt", dm_gnt, 0);
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_dm_rvalid", dm_rvalid, 0);
      chk("rst_dm_err", dm_err, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_dm_rdata", dm_rdata, 0);
      chk("rst_rom_addr", rom_addr, 0);

      // IF-only back-to-back fetches
      drive(0, 1, 32'h0, 0, 0, 32'h0);
      chk("t1c1_if_gnt", if_gnt, 1);
      chk("t1c1_rom_addr", rom_addr, 0);
      chk("t1c1_if_rvalid", if_rvalid, 0);
      drive(0, 1, 32'h4, 0, 0, 32'h0);
      chk("t1c2_if_gnt", if_gnt, 1);
      chk("t1c2_rom_addr", rom_addr, 1);
      chk("t1c2_if_rvalid", if_rvalid, 1);
      chk("t1c2_if_rdata", if_rdata, 32'h0060_8640);
      drive(0, 1, 32'h8, 0, 0, 32'h0);
      chk("t1c3_if_gnt", if_gnt, 1);
      chk("t1c3_rom_addr", rom_addr, 2);
      chk("t1c3_if_rdata", if_rdata, 32'h0068_8040);
      drive(0, 0, 32'h0, 0, 0, 32'h0);
      chk("t1c4_if_gnt", if_gnt, 0);
      chk("t1c4_if_rvalid", if_rvalid, 1);
      chk("t1c4_if_rdata", if_rdata, 32'h0001_0134);
      drive(0, 0, 32'h0, 0, 0, 32'h0);
      chk("t1c5_if_rvalid", if_rvalid, 0);
      chk("t1c5_if_rdata_hold", if_rdata, 32'h0001_0134);
      chk("t1c5_rom_addr_hold", rom_addr, 2);
      exp_if_hold = 32'h0001_0134;

`ifndef ROM_ARB_RR_EN
      // fixed priority with starvation override after MAX_WAIT denials
      for (int k = 1; k <= 4; k++) begin
         drive(0, 1, 32'h104, 0, 1, 32'h100);
         chk($sformatf("t2c%0d_dm_gnt", k), dm_gnt, 1);
         chk($sformatf("t2c%0d_if_gnt", k), if_gnt, 0);
         chk($sformatf("t2c%0d_rom_addr", k), rom_addr, 64);
         chk($sformatf("t2c%0d_dm_rvalid", k), dm_rvalid, (k > 1) ? 1 : 0);
         if (k > 1) chk($sformatf("t2c%0d_dm_rdata", k), dm_rdata, mem[64]);
      end
      drive(0, 1, 32'h104, 0, 1, 32'h100);
      chk("t2c5_if_gnt", if_gnt, 1);
      chk("t2c5_dm_gnt", dm_gnt, 0);
      chk("t2c5_rom_addr", rom_addr, 65);
      chk("t2c5_dm_rvalid", dm_rvalid, 1);
      drive(0, 0, 32'h0, 0, 0, 32'h0);
      chk("t2c6_if_rvalid", if_rvalid, 1);
      chk("t2c6_if_rdata", if_rdata, 32'h2000_0634);
      chk("t2c6_dm_rvalid", dm_rvalid, 0);
      chk("t2c6_dm_rdata_hold", dm_rdata, mem[64]);
      exp_if_hold = 32'h2000_0634;
`endif

      // DM out-of-range handling
      drive(0, 0, 32'h0, 0, 1, 32'h400);
      chk("t3_oor_dm_gnt", dm_gnt, 1);
      chk("t3_oor_rom_addr", rom_addr, 0);
      drive(0, 0, 32'h0, 0, 1, 32'h8);
      chk("t3_oor_dm_rvalid", dm_rvalid, 1);
      chk("t3_oor_dm_err", dm_err, 1);
      chk("t3_oor_dm_rdata", dm_rdata, 0);
      drive(0, 0, 32'h0, 0, 1, 32'h328);
      chk("t3_in_dm_err", dm_err, 0);
      chk("t3_in_dm_rdata", dm_rdata, 32'h0001_0134);
      drive(0, 0, 32'h0, 0, 1, 32'h32C);
      chk("t3_w202_dm_err", dm_err, 0);
      chk("t3_w202_dm_rdata", dm_rdata, mem[202]);
      drive(0, 0, 32'h0, 0, 1, 32'h0001_0004);
      chk("t3_w203_dm_err", dm_err, 1);
      chk("t3_w203_dm_rdata", dm_rdata, 0);
      drive(0, 0, 32'h0, 0, 0, 32'h0);
      chk("t3_upper_dm_rvalid", dm_rvalid, 1);
      chk("t3_upper_dm_err", dm_err, 1);
      chk("t3_upper_dm_rdata", dm_rdata, 0);
      drive(0, 0, 32'h0, 0, 0, 32'h0);
      chk("t3_idle_dm_rvalid", dm_rvalid, 0);
      chk("t3_idle_dm_err", dm_err, 0);

      // flush squashes the due response but not a same-cycle grant
      drive(0, 1, 32'h0, 0, 0, 32'h0);
      chk("t4n_if_gnt", if_gnt, 1);
      drive(0, 1, 32'h4, 1, 0, 32'h0);
      chk("t4n1_if_gnt", if_gnt, 1);
      chk("t4n1_if_rvalid", if_rvalid, 0);
      chk("t4n1_if_rdata_hold", if_rdata, exp_if_hold);
      drive(0, 0, 32'h0, 0, 0, 32'h0);
      chk("t4n2_if_rvalid", if_rvalid, 1);
      chk("t4n2_if_rdata", if_rdata, 32'h0068_8040);

      // reset while a DM response is in flight
      drive(0, 0, 32'h0, 0, 1, 32'h8);
      chk("t5_dm_gnt", dm_gnt, 1);
      drive(1, 0, 32'h0, 0, 0, 32'h0);
      chk("t5_rst_dm_rvalid", dm_rvalid, 0);
      chk("t5_rst_dm_gnt", dm_gnt, 0);
      drive(0, 0, 32'h0, 0, 0, 32'h0);
      chk("t5_post_dm_rvalid", dm_rvalid, 0);
      chk("t5_post_if_rvalid", if_rvalid, 0);
      chk("t5_post_dm_err", dm_err, 0);
      chk("t5_post_if_rdata", if_rdata, 0);
      chk("t5_post_dm_rdata", dm_rdata, 0);
      chk("t5_post_rom_addr", rom_addr, 0);
      chk("t5_post_if_gnt", if_gnt, 0);

`ifdef ROM_ARB_RR_EN
      // round-robin alternation with both requesting
      for (int k = 0; k < 6; k++) begin
         drive(0, 1, 32'h0, 0, 1, 32'h4);
         chk($sformatf("t6c%0d_dm_gnt", k), dm_gnt, (k % 2 == 0) ? 1 : 0);
         chk($sformatf("t6c%0d_if_gnt", k), if_gnt, (k % 2 == 1) ? 1 : 0);
         if (k > 0) begin
            chk($sformatf("t6c%0d_dm_rvalid", k), dm_rvalid, (k % 2 == 1) ? 1 : 0);
            chk($sformatf("t6c%0d_if_rvalid", k), if_rvalid, (k % 2 == 0) ? 1 : 0);
            if (k % 2 == 1) chk($sformatf("t6c%0d_dm_rdata", k), dm_rdata, mem[1]);
            else            chk($sformatf("t6c%0d_if_rdata", k), if_rdata, mem[0]);
         end
      end
`endif

      drive(0, 0, 32'h0, 0, 0, 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
